// File: rtl/vga_capture_if.sv
// Video-in / frame-buffer-write bundle between a video source and vga_capture.
// master drives the pins and consumes writes; slave is the capture block.
interface vga_capture_if #(
    parameter int unsigned WIDTH = 12
);
    logic             hsync;
    logic             vsync;
    logic             data_enable;
    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;
    logic             wr_en;
    logic [18:0]      wr_addr;
    logic [31:0]      wr_data;
    logic [WIDTH-1:0] hdata;
    logic [WIDTH-1:0] vdata;
    logic             locked;
    logic             frame_done;
    logic             sync_error;
    logic [WIDTH-1:0] line_length;

    modport master (
        output hsync, vsync, data_enable, red, green, blue,
        input  wr_en, wr_addr, wr_data, hdata, vdata,
        input  locked, frame_done, sync_error, line_length
    );

    modport slave (
        input  hsync, vsync, data_enable, red, green, blue,
        output wr_en, wr_addr, wr_data, hdata, vdata,
        output locked, frame_done, sync_error, line_length
    );
endinterface

// File: rtl/vga_capture.sv
// Captures a parallel RGB stream into raster-ordered frame-buffer writes,
// gated by a lock FSM that validates frame geometry and measures line length.
module vga_capture #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned HSIZE = 800,
    parameter int unsigned VSIZE = 600,
    parameter bit          HSPP  = 1'b0,
    parameter bit          VSPP  = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    vga_capture_if.slave vid
);
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 32;

    localparam logic [WIDTH-1:0] H_LIM    = WIDTH'(HSIZE);
    localparam logic [WIDTH-1:0] V_LIM    = WIDTH'(VSIZE);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [AW-1:0]    ADDR_LIM = AW'(HSIZE * VSIZE);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic       s1_hs, s1_vs, s1_de;
    logic [7:0] s1_red, s1_green, s1_blue;
    logic       s2_hs, s2_vs, s2_de;

    logic [WIDTH-1:0] x_cnt;
    logic [WIDTH-1:0] y_cnt;
    logic [AW-1:0]    addr_cnt;
    logic [WIDTH-1:0] ll_cnt;
    logic [WIDTH-1:0] ll_meas;
    logic             ll_seen;

    logic             hs_lead, vs_lead, de_rise, de_fall;
    logic [WIDTH-1:0] y_inc;
    logic [WIDTH-1:0] y_eff;
    logic             line_viol, frame_viol, accept;
    logic             wr_c, fd_c, se_c;

    logic             p_wr_en;
    logic [AW-1:0]    p_addr;
    logic [DW-1:0]    p_data;
    logic [WIDTH-1:0] p_hdata;
    logic [WIDTH-1:0] p_vdata;
    logic             p_frame_done;
    logic             p_sync_error;

    // Input sample and edge-history registers; reset to the idle polarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hs    <= ~HSPP;
            s1_vs    <= ~VSPP;
            s1_de    <= 1'b0;
            s1_red   <= '0;
            s1_green <= '0;
            s1_blue  <= '0;
            s2_hs    <= ~HSPP;
            s2_vs    <= ~VSPP;
            s2_de    <= 1'b0;
        end else begin
            s1_hs    <= vid.hsync;
            s1_vs    <= vid.vsync;
            s1_de    <= vid.data_enable;
            s1_red   <= vid.red;
            s1_green <= vid.green;
            s1_blue  <= vid.blue;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            s2_de    <= s1_de;
        end
    end

    assign hs_lead = (s1_hs == HSPP) && (s2_hs != HSPP);
    assign vs_lead = (s1_vs == VSPP) && (s2_vs != VSPP);
    assign de_rise = s1_de && !s2_de;
    assign de_fall = !s1_de && s2_de;

    // A line ending in the vsync cycle is counted before the frame is judged.
    assign y_inc = (y_cnt == CNT_MAX) ? y_cnt : y_cnt + WIDTH'(1);
    assign y_eff = de_fall ? y_inc : y_cnt;

    assign line_viol  = (de_fall && (x_cnt != H_LIM)) || (s1_de && (x_cnt >= H_LIM));
    assign frame_viol = (vs_lead && (y_eff != V_LIM)) || (de_rise && (y_cnt >= V_LIM));
    assign accept     = s1_de && (x_cnt < H_LIM) && (y_cnt < V_LIM) && (addr_cnt < ADDR_LIM);

    // Coordinate and address counters run in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else begin
            if (hs_lead || de_fall) begin
                x_cnt <= '0;
            end else if (s1_de && (x_cnt < H_LIM)) begin
                x_cnt <= x_cnt + WIDTH'(1);
            end

            if (vs_lead) begin
                y_cnt <= '0;
            end else if (de_fall) begin
                y_cnt <= y_inc;
            end

            if (vs_lead) begin
                addr_cnt <= '0;
            end else if (accept) begin
                addr_cnt <= addr_cnt + AW'(1);
            end
        end
    end

    // Line length: clocks between consecutive hsync leading edges, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            ll_cnt  <= '0;
            ll_meas <= '0;
            ll_seen <= 1'b0;
        end else if (hs_lead) begin
            ll_cnt  <= WIDTH'(1);
            ll_seen <= 1'b1;
            if (ll_seen) begin
                ll_meas <= ll_cnt;
            end
        end else if (ll_cnt != CNT_MAX) begin
            ll_cnt <= ll_cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_SEARCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        wr_c    = 1'b0;
        fd_c    = 1'b0;
        se_c    = 1'b0;
        unique case (state)
            S_SEARCH: begin
                if (vs_lead) begin
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (line_viol || frame_viol) begin
                    state_n = S_SEARCH;
                    se_c    = 1'b1;
                end else if (vs_lead) begin
                    state_n = S_LOCKED;
                end
            end
            S_LOCKED: begin
                wr_c = accept;
                if (line_viol || frame_viol) begin
                    state_n = S_SEARCH;
                    se_c    = 1'b1;
                end else if (vs_lead) begin
                    fd_c = 1'b1;
                end
            end
            default: begin
                state_n = S_SEARCH;
            end
        endcase
    end

    // Decision stage: capture the pixel and its coordinates with the write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_wr_en      <= 1'b0;
            p_addr       <= '0;
            p_data       <= '0;
            p_hdata      <= '0;
            p_vdata      <= '0;
            p_frame_done <= 1'b0;
            p_sync_error <= 1'b0;
        end else begin
            p_wr_en      <= wr_c;
            p_addr       <= addr_cnt;
            p_data       <= {8'h00, s1_red, s1_green, s1_blue};
            p_hdata      <= x_cnt;
            p_vdata      <= y_cnt;
            p_frame_done <= fd_c;
            p_sync_error <= se_c;
        end
    end

    // Output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid.wr_en       <= 1'b0;
            vid.wr_addr     <= '0;
            vid.wr_data     <= '0;
            vid.hdata       <= '0;
            vid.vdata       <= '0;
            vid.locked      <= 1'b0;
            vid.frame_done  <= 1'b0;
            vid.sync_error  <= 1'b0;
            vid.line_length <= '0;
        end else begin
            vid.wr_en       <= p_wr_en;
            vid.wr_addr     <= p_addr;
            vid.wr_data     <= p_data;
            vid.hdata       <= p_hdata;
            vid.vdata       <= p_vdata;
            vid.locked      <= (state == S_LOCKED);
            vid.frame_done  <= p_frame_done;
            vid.sync_error  <= p_sync_error;
            vid.line_length <= ll_meas;
        end
    end
endmodule
